// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter
// Shares the single timer register port among N_REQ requesters and runs one
// transaction at a time through IDLE -> ISSUE -> (WAIT) -> RESP.
// Optional feature: define TIMER_ARB_ROUND_ROBIN_EN for round-robin
// arbitration. Without it the lowest requesting index always wins and no
// pointer register is built.
// req_ready is decoded from the IDLE state and the current requests, so a
// requester sees its accept in the same cycle its request is presented. All
// timer and response outputs come straight from registers.

module timer_bus_arbiter #(
    parameter int N_REQ  = 3,
    parameter int RD_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [4*N_REQ-1:0]    req_cmd,
    input  logic [32*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [3:0]            tmr_cmd,
    output logic                  tmr_wr_en,
    output logic                  tmr_rd_en,
    output logic [31:0]           tmr_wr_data,
    input  logic [31:0]           tmr_rd_data
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // WAIT counts down from RD_LAT-1 to 0; the sample happens on the last WAIT cycle.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       gnt_q;
    logic                we_q;
    logic [3:0]          cmd_q;
    logic [31:0]         wdata_q;
    logic [1:0]          cnt_q;

    logic [3:0]          tmr_cmd_q;
    logic [31:0]         tmr_wr_data_q;
    logic                tmr_wr_en_q;
    logic                tmr_rd_en_q;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic                rsp_err_q;
    logic [31:0]         rsp_rdata_q;

`ifdef TIMER_ARB_ROUND_ROBIN_EN
    logic [IW-1:0]       ptr_q;
    logic [2*N_REQ-1:0]  dbl_s;
    logic [N_REQ-1:0]    rot_s;
    int                  sum_s;
`endif

    logic                found_s;
    logic [IW-1:0]       win_s;
    logic                sel_we_s;
    logic [3:0]          sel_cmd_s;
    logic [31:0]         sel_wdata_s;

    // Registers 0..3 exist in the timer; anything above is rejected with an error.
    function automatic logic cmd_legal(input logic [3:0] cmd);
        return (cmd <= 4'h3);
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Winner selection among the current requests.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
`ifdef TIMER_ARB_ROUND_ROBIN_EN
        // Rotate so that bit 0 corresponds to the pointer, then take the first hit.
        dbl_s = {req_valid, req_valid} >> ptr_q;
        rot_s = dbl_s[N_REQ-1:0];
        sum_s = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                found_s = 1'b1;
                sum_s   = k + int'(ptr_q);
            end else begin
                sum_s = sum_s;
            end
        end
        if (sum_s >= N_REQ) begin
            win_s = IW'(sum_s - N_REQ);
        end else begin
            win_s = IW'(sum_s);
        end
`else
        // Scan downward so the lowest requesting index is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                found_s = 1'b1;
                win_s   = IW'(k);
            end else begin
                win_s = win_s;
            end
        end
`endif
    end

    // Payload mux for the selected requester.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_cmd_s   = 4'h0;
        sel_wdata_s = 32'h0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_s == IW'(k)) begin
                sel_we_s    = req_we[k];
                sel_cmd_s   = req_cmd[4*k +: 4];
                sel_wdata_s = req_wdata[32*k +: 32];
            end else begin
                sel_we_s = sel_we_s;
            end
        end
    end

    // Accept strobe: only in IDLE, only to the winner, suppressed while reset is high.
    always_comb begin
        if ((state_q == ST_IDLE) && !rst && found_s) begin
            req_ready = onehot(win_s);
        end else begin
            req_ready = '0;
        end
    end

    // Transaction FSM with registered timer and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            we_q          <= 1'b0;
            cmd_q         <= 4'h0;
            wdata_q       <= 32'h0;
            cnt_q         <= 2'd0;
            tmr_cmd_q     <= 4'h0;
            tmr_wr_data_q <= 32'h0;
            tmr_wr_en_q   <= 1'b0;
            tmr_rd_en_q   <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'h0;
`ifdef TIMER_ARB_ROUND_ROBIN_EN
            ptr_q         <= '0;
`endif
        end else begin
            // Outputs are single-cycle pulses; they drop unless a state below sets them.
            tmr_cmd_q     <= 4'h0;
            tmr_wr_data_q <= 32'h0;
            tmr_wr_en_q   <= 1'b0;
            tmr_rd_en_q   <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt_q         <= win_s;
                        we_q          <= sel_we_s;
                        cmd_q         <= sel_cmd_s;
                        wdata_q       <= sel_wdata_s;
                        tmr_cmd_q     <= sel_cmd_s;
                        tmr_wr_data_q <= sel_wdata_s;
                        tmr_wr_en_q   <= cmd_legal(sel_cmd_s) & sel_we_s;
                        tmr_rd_en_q   <= cmd_legal(sel_cmd_s) & ~sel_we_s;
                        state_q       <= ST_ISSUE;
`ifdef TIMER_ARB_ROUND_ROBIN_EN
                        if (win_s == IW'(N_REQ - 1)) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= win_s + IW'(1);
                        end
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!cmd_legal(cmd_q) || we_q) begin
                        // Writes and rejected commands complete without waiting.
                        rsp_valid_q <= onehot(gnt_q);
                        rsp_err_q   <= ~cmd_legal(cmd_q);
                        state_q     <= ST_RESP;
                    end else if (RD_LAT == 0) begin
                        rsp_valid_q <= onehot(gnt_q);
                        rsp_rdata_q <= tmr_rd_data;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q   <= WAIT_INIT;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rsp_valid_q <= onehot(gnt_q);
                        rsp_rdata_q <= tmr_rd_data;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tmr_cmd     = tmr_cmd_q;
    assign tmr_wr_data = tmr_wr_data_q;
    assign tmr_wr_en   = tmr_wr_en_q;
    assign tmr_rd_en   = tmr_rd_en_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: doc/timer_bus_arbiter.md
TIMER_BUS_ARBITER -- requirements
Module: timer_bus_arbiter

Interface
REQ-001 Parameter: N_REQ, default 3, number of requesters sharing the timer register port (2..8).
REQ-002 Parameter: RD_LAT, default 0, cycles between the timer read strobe and rd data valid (0..3).
REQ-003 Port: clk  input  1  clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  N_REQ  per-requester transaction request.
REQ-006 Port: req_we  input  N_REQ  per-requester 1=write, 0=read.
REQ-007 Port: req_cmd  input  4*N_REQ  per-requester register select (slice i = [4i+3:4i]).
REQ-008 Port: req_wdata  input  32*N_REQ  per-requester write data.
REQ-009 Port: req_ready  output  N_REQ  one-hot accept strobe.
REQ-010 Port: rsp_valid  output  N_REQ  one-hot completion strobe.
REQ-011 Port: rsp_rdata  output  32  read data; shared across requesters.
REQ-012 Port: rsp_err  output  1  completion carries an error; qualified by rsp_valid.
REQ-013 Port: tmr_cmd  output  4  register select to timer.
REQ-014 Port: tmr_wr_en, tmr_rd_en  output  1 each  timer strobes.
REQ-015 Port: tmr_wr_data  output  32  write data to timer.
REQ-016 Port: tmr_rd_data  input  32  read data from timer.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-018 IDLE: if any req_valid set, select winner g, latch req_we/req_cmd/req_wdata slice g, pulse req_ready[g] for that cycle, go ISSUE; otherwise stay in IDLE.
REQ-019 Accept is a valid&ready handshake. A requester holds valid and payload until ready. Dropping valid before ready is legal and cancels that request.
REQ-020 ISSUE lasts 1 cycle and drives tmr_cmd and tmr_wr_data from the latch. It asserts exactly one of tmr_wr_en/tmr_rd_en per latched we.
REQ-021 Write: ISSUE -> RESP.
REQ-022 Read with RD_LAT=0: sample tmr_rd_data at end of ISSUE, then -> RESP. Read with RD_LAT>0: -> WAIT for RD_LAT cycles, then sample and -> RESP.
REQ-023 RESP lasts 1 cycle: rsp_valid[g]=1, rsp_rdata=sampled data (reads) or 0 (writes), rsp_err=0, -> IDLE.
REQ-024 Illegal cmd (>4'h3): no timer strobe. ISSUE -> RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 Outside ISSUE: tmr_wr_en=tmr_rd_en=0, tmr_cmd=0, tmr_wr_data=0.
REQ-026 Outside RESP: rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-027 Minimum transaction period: writes 3 cycles, IDLE to IDLE. Reads take 3+RD_LAT cycles.
REQ-028 A requester asserting valid in the RESP cycle of its own previous transaction is eligible in the following IDLE cycle.

Reset
REQ-029 rst forces IDLE and clears the latched payload and the WAIT counter. It sets the round-robin pointer to 0 and drives all outputs to 0 in the next cycle.
REQ-030 rst mid-transaction aborts it with no rsp_valid. A timer strobe already issued is not retracted.
REQ-031 rst has priority over every other event.

Configuration
REQ-032 Macro TIMER_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
- Search starts at pointer p.
- After a grant to g, p <= (g+1) mod N_REQ.
- A continuously requesting requester waits at most N_REQ-1 grants.
REQ-033 Macro TIMER_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. No pointer register exists.

Verification
REQ-034 Write path, N_REQ=3, RD_LAT=0.
- Stimulus: req1 writes cmd=1, wdata=0x0000_1234.
- req_ready[1] in cycle 0.
- ISSUE in cycle 1: tmr_wr_en=1, tmr_cmd=1, tmr_wr_data=0x1234.
- Cycle 2: rsp_valid[1]=1, rsp_err=0.
REQ-035 Read path, RD_LAT=2.
- Stimulus: req0 reads cmd=2, tmr_rd_data=0xDEAD_BEEF.
- tmr_rd_en pulses 1 cycle, followed by 2 WAIT cycles.
- Next cycle: rsp_valid[0]=1, rsp_rdata=0xDEADBEEF.
REQ-036 Continuous requests, all 3 held valid for 9 transactions.
- With macro defined: grant order 0,1,2,0,1,2,0,1,2.
- With macro undefined: grants are all to 0.
REQ-037 Illegal command: req2 reads cmd=4'h7.
- No tmr_rd_en/tmr_wr_en.
- rsp_valid[2]=1, rsp_err=1, rsp_rdata=0.
REQ-038 Reset mid-read: rst asserted in a WAIT cycle, RD_LAT=3.
- No rsp_valid.
- FSM back in IDLE next cycle, all outputs 0.
- Pointer is 0, so a subsequent simultaneous req0/req1 grants 0.
